psum_ofifo: RTL and testbench
=============================

// Module: psum_ofifo
// PURPOSE
//  Output FIFO directly downstream of the MAC array. Captures the per-column partial sums
//  (out_s) when each column's valid bit is high. Columns drain at skewed times, so each
//  column is buffered in its own FIFO. Full rows (one word from every column) are presented
//  to the SFU/SRAM writeback stage, which pops them all at once.
// PARAMETERS
//  col      8   number of array columns (= number of independent column FIFOs)
//  psum_bw  16  width of one partial sum
//  depth    64  entries per column FIFO; power of two, >=2
// PORTS
//  clk       in   1            rising-edge clock
//  reset     in   1            synchronous, active-high reset
//  wr        in   col          per-column write strobe (MAC array valid)
//  in        in   col*psum_bw  per-column data (MAC array out_s); column c = bits [psum_bw*(c+1)-1:psum_bw*c]
//  rd        in   1            pop one word from every column
//  out       out  col*psum_bw  head word of each column, same column packing as in
//  o_valid   out  1            every column FIFO is non-empty (a full row is available)
//  o_full    out  1            at least one column FIFO is full
//  o_ovf     out  1            sticky: a write was dropped because its column was full
//  o_level   out  log2(depth)+1 occupancy of column 0 (0..depth)
// BEHAVIOUR
//  - Each column c has a depth x psum_bw memory, a write pointer and a read pointer.
//    Both pointers are log2(depth)+1 bits; the extra MSB separates full from empty.
//    Pointers wrap modulo 2*depth.
//  - Write, column c: on a clk edge with wr[c]=1 and column c not full, the column stores in[c]
//    at wptr[c] and increments wptr[c]. Columns write independently; any subset of wr may be high.
//  - Write to a full column: data is dropped, wptr is unchanged, and o_ovf is set to 1.
//    o_ovf stays 1 until reset. The other columns written in the same cycle proceed normally.
//  - o_valid: combinational, the AND over all columns of (wptr[c] != rptr[c]).
//  - Read: on a clk edge with rd=1 and o_valid=1, every rptr[c] increments.
//    rd while o_valid=0 is ignored: no pointer moves and no error is raised.
//  - out (first-word-fall-through):
//    - o_valid=1: out is combinationally the head word mem[c][rptr[c]] of each column.
//    - o_valid=0: out is forced to all zeros.
//    - After a pop, the next row appears the same cycle the pointers update. Read latency is 0 cycles.
//  - Simultaneous write and read on a column:
//    - Both take effect; that column's occupancy is unchanged.
//    - The full test uses the occupancy before the edge. A write to a full column in the same
//      cycle as a pop is therefore still dropped and sets o_ovf.
//  - Write to an empty column is visible at out (if all other columns are non-empty)
//    the cycle after the write edge. There is no same-cycle bypass.
//  - o_full: combinational, the OR over all columns of (wptr[c]-rptr[c] == depth).
//  - o_level: combinational, wptr[0]-rptr[0].
//  - Reset (also mid-operation): all pointers <= 0 and o_ovf <= 0, giving o_valid=0, o_full=0,
//    o_level=0, out=0. Memory is not cleared, and stale contents are never observable.
//    wr and rd are ignored in the reset cycle.
//  - Arithmetic: pointers increment modulo 2*depth. No arithmetic is performed on the data;
//    words pass through bit-exact.
// TESTING
//  1. Reset, then wr=8'hFF for 1 cycle with column c = 16'h0100+c.
//     -> o_valid=1 the next cycle; out column c = 16'h0100+c; o_level=1.
//     Then rd=1 for 1 cycle -> o_valid=0, out=0.
//  2. Skewed fill: wr[c] pulses at cycle t+c, c=0..7.
//     -> o_valid stays 0 until the cycle after column 7's write, then goes to 1 with the correct row.
//  3. Fill column 0 with 64 writes while the others stay empty.
//     -> o_full=1, o_level=64, o_valid=0.
//     A 65th write -> o_ovf=1 and o_level stays 64.
//     o_ovf persists after later traffic until reset.
//  4. All columns hold 3 rows; assert wr=8'hFF and rd=1 together for 10 cycles.
//     -> o_level stays 3; the popped rows are in exact FIFO order; no overflow.
//  5. rd=1 with all FIFOs empty for 5 cycles -> pointers unchanged, o_valid=0, o_ovf=0.
//     A later write/read round-trip is correct.
//  6. Reset asserted with 20 rows buffered -> next cycle o_valid=0, o_level=0, out=0, o_ovf=0.
//     A new row written afterwards reads back exactly, with no stale data.
//  Pointer wrap: stream 200 rows through with depth=64, with random rd gaps.
//  -> the output sequence equals the input sequence per column.

Source files
------------

// File: rtl/psum_ofifo.sv
// Purpose     : per-column output FIFOs behind the MAC array; presents only complete rows downstream.
// Latency     : a written word is visible at the head the cycle after its write edge; pops are 0-cycle FWFT.
// Backpressure: none upstream (writes to a full column are dropped and flagged sticky in o_ovf);
//               downstream pops with rd, which is honoured only while o_valid is high.
//
// Ports:
//   clk, reset  rising-edge clock, synchronous active-high reset
//   wr[col]     per-column write strobe; in packs column c at [psum_bw*(c+1)-1 : psum_bw*c]
//   rd          pop one word from every column (ignored unless o_valid)
//   out         head word of every column, zero while o_valid is low
//   o_valid     all columns non-empty
//   o_full      at least one column full
//   o_ovf       sticky dropped-write flag
//   o_level     occupancy of column 0

// Purpose     : single-column synchronous FIFO with first-word-fall-through head.
// Latency     : write visible at head one cycle after the write edge; pop takes effect on the edge.
// Backpressure: pushes while full are silently ignored; the parent flags them.
module psum_col_fifo #(
  parameter int DW = 16,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdat,
  output logic [DW-1:0] head,
  output logic [AW:0]   level
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem [2**AW];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          full;
  logic          empty;

  // Pointers carry one extra MSB so that full (diff == depth) and empty (equal) differ.
  assign level = wptr - rptr;
  assign full  = (level == DEPTH);
  assign empty = (wptr == rptr);
  assign head  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      // Full/empty are judged on pre-edge occupancy, so a push into a full
      // column is dropped even when a pop happens on the same edge.
      if (push && !full)
        wptr <= wptr + (AW+1)'(1);
      if (pop && !empty)
        rptr <= rptr + (AW+1)'(1);
    end
  end

  // Storage is not reset; pointers reset, so stale words are never exposed.
  always_ff @(posedge clk) begin
    if (!reset && push && !full)
      mem[wptr[AW-1:0]] <= wdat;
  end

endmodule

module psum_ofifo #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [col-1:0]             wr,
  input  logic [col*psum_bw-1:0]     in,
  input  logic                       rd,
  output logic [col*psum_bw-1:0]     out,
  output logic                       o_valid,
  output logic                       o_full,
  output logic                       o_ovf,
  output logic [$clog2(depth):0]     o_level
);

  localparam int AW = $clog2(depth);
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [AW:0]            lvl [col];
  logic [col-1:0]         col_full;
  logic [col-1:0]         col_nonempty;
  logic [col*psum_bw-1:0] heads;
  logic                   pop;

  // A row pops only when every column has a word, so all read pointers move together.
  assign pop = rd && o_valid;

  for (genvar c = 0; c < col; c++) begin : g_col
    psum_col_fifo #(
      .DW (psum_bw),
      .AW (AW)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (wr[c]),
      .pop   (pop),
      .wdat  (in[psum_bw*c +: psum_bw]),
      .head  (heads[psum_bw*c +: psum_bw]),
      .level (lvl[c])
    );

    assign col_full[c]     = (lvl[c] == DEPTH);
    assign col_nonempty[c] = (lvl[c] != '0);
  end

  assign o_valid = &col_nonempty;
  assign o_full  = |col_full;
  assign o_level = lvl[0];
  assign out     = o_valid ? heads : '0;

  always_ff @(posedge clk) begin
    if (reset)
      o_ovf <= 1'b0;
    else if (|(wr & col_full))
      o_ovf <= 1'b1;
  end

endmodule

// File: tb/tb_psum_ofifo.sv
module tb_psum_ofifo;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   wr;
  logic [127:0] din;
  logic         rd;
  logic [127:0] dout;
  logic         o_valid;
  logic         o_full;
  logic         o_ovf;
  logic [6:0]   o_level;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0]  q [8][$];
  bit           exp_ovf;

  logic [127:0] mon_exp;
  bit           mon_ok;

  always #5 clk = ~clk;

  psum_ofifo #(.col(8), .psum_bw(16), .depth(64)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr      (wr),
    .in      (din),
    .rd      (rd),
    .out     (dout),
    .o_valid (o_valid),
    .o_full  (o_full),
    .o_ovf   (o_ovf),
    .o_level (o_level)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] row(input logic [15:0] base);
    logic [127:0] r;
    for (int c = 0; c < 8; c++) r[c*16 +: 16] = base + 16'(c);
    return r;
  endfunction

  // Drive one cycle of stimulus; expected words go into the per-column queues
  // unless the column already holds 64 words before this edge.
  task automatic cyc(input logic [7:0] w, input logic [127:0] d, input logic r);
    wr  = w;
    din = d;
    rd  = r;
    for (int c = 0; c < 8; c++) begin
      if (w[c]) begin
        if (q[c].size() < 64) q[c].push_back(d[c*16 +: 16]);
        else exp_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    wr  = '0;
    din = '0;
    rd  = 1'b0;
  endtask

  task automatic do_reset(input logic [7:0] w, input logic r);
    reset = 1'b1;
    wr    = w;
    rd    = r;
    din   = '1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    wr    = '0;
    rd    = 1'b0;
    din   = '0;
    for (int c = 0; c < 8; c++) q[c].delete();
    exp_ovf = 1'b0;
  endtask

  // Monitor: on every accepted pop compare the presented row to the queue heads.
  always @(negedge clk) begin
    if (!reset) begin
      if (rd && o_valid) begin
        mon_ok  = 1'b1;
        mon_exp = '0;
        for (int c = 0; c < 8; c++) begin
          if (q[c].size() == 0) mon_ok = 1'b0;
          else mon_exp[c*16 +: 16] = q[c].pop_front();
        end
        n_cmp++;
        if (!mon_ok || dout !== mon_exp) begin
          n_bad++;
          $display("FAIL row_pop: got %h expected %h (model_has_row=%0d)", dout, mon_exp, mon_ok);
        end
      end
      if (!o_valid) begin
        n_cmp++;
        if (dout !== '0) begin
          n_bad++;
          $display("FAIL out_zero: got %h expected 0", dout);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]   w;
    logic [127:0] d;
    int           cnt [8];
    int           guard;
    bit           done;

    reset = 1'b1; wr = '0; rd = 1'b0; din = '0; exp_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset(8'h00, 1'b0);
    chk("rst_valid", o_valid, 0);
    chk("rst_level", o_level, 0);
    chk("rst_full",  o_full,  0);
    chk("rst_ovf",   o_ovf,   0);
    chk("rst_out",   dout,    0);

    // 1: single full row round-trip
    cyc(8'hFF, row(16'h0100), 1'b0);
    chk("t1_valid", o_valid, 1);
    chk("t1_out",   dout, 128'h0107_0106_0105_0104_0103_0102_0101_0100);
    chk("t1_level", o_level, 1);
    cyc(8'h00, '0, 1'b1);
    chk("t1_pop_valid", o_valid, 0);
    chk("t1_pop_out",   dout, 0);

    // 2: skewed fill, one column per cycle
    for (int c = 0; c < 8; c++) begin
      d = '0;
      d[c*16 +: 16] = 16'h0200 + 16'(c);
      cyc(8'(1 << c), d, 1'b0);
      if (c < 7) chk("t2_valid_low", o_valid, 0);
    end
    chk("t2_valid", o_valid, 1);
    chk("t2_out",   dout, 128'h0207_0206_0205_0204_0203_0202_0201_0200);
    cyc(8'h00, '0, 1'b1);

    // 3: fill column 0 to capacity, then overflow
    for (int i = 0; i < 64; i++) cyc(8'h01, 128'(16'h0300 + 16'(i)), 1'b0);
    chk("t3_full",  o_full,  1);
    chk("t3_level", o_level, 64);
    chk("t3_valid", o_valid, 0);
    chk("t3_ovf0",  o_ovf,   0);
    cyc(8'h01, 128'hDEAD, 1'b0);
    chk("t3_ovf",       o_ovf,   1);
    chk("t3_level_ovf", o_level, 64);
    cyc(8'hFE, row(16'h0310), 1'b0);
    cyc(8'h00, '0, 1'b1);
    chk("t3_ovf_sticky", o_ovf,   1);
    chk("t3_level_pop",  o_level, 63);
    do_reset(8'h00, 1'b0);
    chk("t3_ovf_clr", o_ovf, 0);

    // 4: steady-state simultaneous write and pop at occupancy 3
    for (int i = 0; i < 3; i++) cyc(8'hFF, row(16'h0400 + 16'(i << 4)), 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(8'hFF, row(16'h0500 + 16'(i << 4)), 1'b1);
      chk("t4_level", o_level, 3);
    end
    chk("t4_ovf", o_ovf, 0);
    for (int i = 0; i < 3; i++) cyc(8'h00, '0, 1'b1);
    chk("t4_empty", o_valid, 0);

    // 5: pops while empty are ignored
    for (int i = 0; i < 5; i++) cyc(8'h00, '0, 1'b1);
    chk("t5_valid", o_valid, 0);
    chk("t5_level", o_level, 0);
    chk("t5_ovf",   o_ovf,   0);
    cyc(8'hFF, row(16'h0600), 1'b0);
    chk("t5_out", dout, 128'h0607_0606_0605_0604_0603_0602_0601_0600);
    cyc(8'h00, '0, 1'b1);
    chk("t5_level_after", o_level, 0);

    // 6: reset with 20 rows buffered, wr/rd active during reset
    for (int i = 0; i < 20; i++) cyc(8'hFF, row(16'h0700 + 16'(i << 4)), 1'b0);
    chk("t6_level_pre", o_level, 20);
    do_reset(8'hFF, 1'b1);
    chk("t6_valid", o_valid, 0);
    chk("t6_level", o_level, 0);
    chk("t6_out",   dout,    0);
    chk("t6_ovf",   o_ovf,   0);
    cyc(8'hFF, row(16'h0800), 1'b0);
    chk("t6_out_new", dout, 128'h0807_0806_0805_0804_0803_0802_0801_0800);
    chk("t6_level_new", o_level, 1);
    cyc(8'h00, '0, 1'b1);

    // Pointer wrap: 200 words per column with random write skew and pop gaps
    for (int c = 0; c < 8; c++) cnt[c] = 0;
    guard = 0;
    done  = 1'b0;
    while (!done && guard < 5000) begin
      w = '0;
      d = '0;
      for (int c = 0; c < 8; c++) begin
        if (cnt[c] < 200 && q[c].size() < 64 && $urandom_range(0, 3) != 0) begin
          w[c] = 1'b1;
          d[c*16 +: 16] = {c[3:0], 12'(cnt[c])};
          cnt[c]++;
        end
      end
      cyc(w, d, $urandom_range(0, 2) != 0);
      done = 1'b1;
      for (int c = 0; c < 8; c++) if (cnt[c] < 200) done = 1'b0;
      guard++;
    end
    chk("wrap_stream_done", done, 1);
    guard = 0;
    while (o_valid && guard < 600) begin
      cyc(8'h00, '0, 1'b1);
      guard++;
    end
    chk("wrap_drain_valid", o_valid, 0);
    chk("wrap_drain_level", o_level, 0);
    chk("wrap_ovf",         o_ovf,   exp_ovf);
    for (int c = 0; c < 8; c++) chk("wrap_model_empty", q[c].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
